comp_n_1bit_out: RTL and testbench



---
 rtl/comp_n_1bit_out.sv | 98 +++++++++
 tb/tb_comp_n_1bit_out.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/comp_n_1bit_out.sv
// N-bit equality comparator: XNOR stage plus 4-ary AND tree, registered copy.
// Define COMP_N_GATE_DELAY_EN to give every gate and the flop a 0.05 ns delay.
`timescale 1ns/1ps

`ifdef COMP_N_GATE_DELAY_EN
`define COMP_N_GD #0.05
`else
`define COMP_N_GD
`endif

module comp_n_1bit_out #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out,
  output logic         out_q
);

  function automatic int lw(input int l);
    int w;
    w = N;
    for (int k = 0; k < l; k++)
      w = (w + 3) / 4;
    return w;
  endfunction

  function automatic int nlv();
    int w;
    int c;
    w = N;
    c = 0;
    while (w > 1) begin
      w = (w + 3) / 4;
      c++;
    end
    return c;
  endfunction

  // Nodes of all levels are packed back to back in nd.
  function automatic int off(input int l);
    int s;
    s = 0;
    for (int k = 0; k < l; k++)
      s += lw(k);
    return s;
  endfunction

  localparam int LV  = nlv();
  localparam int TOT = off(LV) + 1;

  wire [TOT-1:0] nd;

  for (genvar i = 0; i < N; i++) begin : g_x
    xnor `COMP_N_GD u_x (nd[i], A[i], B[i]);
  end

  for (genvar l = 0; l < LV; l++) begin : g_l
    localparam int W  = lw(l);
    localparam int NG = (W + 3) / 4;
    localparam int IB = off(l);
    localparam int OB = off(l + 1);
    for (genvar g = 0; g < NG; g++) begin : g_g
      localparam int C = (W - 4*g > 4) ? 4 : W - 4*g;
      localparam int P = IB + 4*g;
      if (C == 4) begin : g_a4
        and `COMP_N_GD u_a (nd[OB+g], nd[P], nd[P+1],
                            nd[P+2], nd[P+3]);
      end else if (C == 3) begin : g_a3
        and `COMP_N_GD u_a (nd[OB+g], nd[P], nd[P+1],
                            nd[P+2]);
      end else if (C == 2) begin : g_a2
        and `COMP_N_GD u_a (nd[OB+g], nd[P], nd[P+1]);
      end else begin : g_b1
        buf `COMP_N_GD u_b (nd[OB+g], nd[P]);
      end
    end
  end

  assign out = nd[TOT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      out_q <= 1'b0;
    else if (en)
`ifdef COMP_N_GATE_DELAY_EN
      out_q <= #0.05 out;
`else
      out_q <= out;
`endif
  end

endmodule

`undef COMP_N_GD

// File: tb/tb_comp_n_1bit_out.sv
// Scoreboard bench for comp_n_1bit_out: stimulus queues expectations,
// a monitor pops and compares them against the live outputs.
`timescale 1ns/1ps

module tb_comp_n_1bit_out;

  typedef struct {
    int    sel;
    logic  exp;
    string nm;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [63:0] a;
  logic [63:0] b;
  logic [4:0]  a5;
  logic [4:0]  b5;
  logic        o;
  logic        oq;
  logic        o5;
  logic        oq5;

  item_t sbq[$];
  int    nvec = 0;
  int    nerr = 0;

  always #5 clk = ~clk;

  comp_n_1bit_out #(.N(64)) u64 (
    .clk(clk), .reset(rst_n), .en(en),
    .A(a), .B(b), .out(o), .out_q(oq)
  );

  comp_n_1bit_out #(.N(5)) u5 (
    .clk(clk), .reset(rst_n), .en(en),
    .A(a5), .B(b5), .out(o5), .out_q(oq5)
  );

  task automatic put(input int sel, input logic exp,
                     input string nm);
    item_t it;
    it.sel = sel;
    it.exp = exp;
    it.nm  = nm;
    sbq.push_back(it);
  endtask

  task automatic chk(input int sel, input logic exp,
                     input string nm);
    put(sel, exp, nm);
    #1;
  endtask

  initial begin : monitor
    item_t it;
    logic  act;
    forever begin
      wait (sbq.size() != 0);
      it = sbq.pop_front();
      case (it.sel)
        0:       act = o;
        1:       act = oq;
        default: act = o5;
      endcase
      nvec++;
      if (act !== it.exp) begin
        nerr++;
        $display("FAIL %s: got %b want %b", it.nm, act, it.exp);
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    a5    = '0;
    b5    = '0;
    #3;
    chk(1, 1'b0, "reset_q");
    chk(0, 1'b1, "zero_eq");

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    #1;
    chk(1, 1'b1, "first_capture");

    @(negedge clk);
    en = 1'b0;
    a  = 64'h1;
    #1;
    chk(0, 1'b0, "bit0");
    a = 64'h8000_0000_0000_0000;
    #1;
    chk(0, 1'b0, "bit63");
    a = 64'h0000_0000_8000_0000;
    #1;
    chk(0, 1'b0, "bit31");
    a = 64'hDEAD_BEEF_0123_4567;
    b = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk(0, 1'b1, "dead_eq");
    b[17] = ~b[17];
    #1;
    chk(0, 1'b0, "dead_b17");
    @(posedge clk);
    #1;
    chk(1, 1'b1, "en0_hold");

    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk(1, 1'b0, "capture_ne");
    @(negedge clk);
    b = a;
    @(posedge clk);
    #1;
    chk(1, 1'b1, "capture_eq");

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(1, 1'b0, "async_rst");
    chk(0, 1'b1, "out_in_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk(1, 1'b0, "rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(1, 1'b0, "release_pre");
    @(posedge clk);
    #1;
    chk(1, 1'b1, "release_cap");

    a5 = 5'h15;
    b5 = 5'h15;
    #1;
    chk(2, 1'b1, "n5_eq");
    for (int i = 0; i < 5; i++) begin
      b5 = 5'h15 ^ (5'h1 << i);
      #1;
      chk(2, 1'b0, "n5_bit");
    end
    a5 = 5'h1f;
    b5 = 5'h1f;
    #1;
    chk(2, 1'b1, "n5_ones");

`ifdef COMP_N_GATE_DELAY_EN
    a = '0;
    b = '0;
    #2;
    a = 64'h1;
    #0.19;
    put(0, 1'b1, "dly_pre");
    #0.02;
    put(0, 1'b0, "dly_post");
    #1;
`endif

    #5;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
